// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo_pkg : shared types, MMIO offsets and helpers for the UART RX
// Revision: 1.0
// ============================================================================
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  localparam logic [31:0] UART_BASE_ADDR    = 32'h8000_0000;
  localparam logic [31:0] UART_RX_DATA      = 32'h0000_0008;
  localparam logic [31:0] UART_RX_STAT      = 32'h0000_000C;
  localparam int          UART_CLKS_PER_BIT = 868;

  // Expected parity bit; unused upper data bits must be zero.
  function automatic logic data_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : first-word-fall-through FIFO with occupancy count
// Revision: 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : UART receiver (configurable framing) feeding an RX FIFO
// Revision: 1.0
// ============================================================================
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_in,
  input  logic                            rd_en,
  output logic [DATA_BITS-1:0]            rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            frame_err,
  output logic                            parity_err,
  output logic                            overrun_err,
  input  logic                            err_clr
);

  localparam int            CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  logic [1:0]           sync_q;
  logic                 rx_s;
  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 bad_q, bad_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 push, frame_evt, parity_evt, overrun_evt;
  logic                 tick;
  logic                 fifo_full, fifo_empty;

  assign rx_s = sync_q[1];
  assign tick = (baud_q == '0);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    bad_d      = bad_q;
    push       = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          baud_d  = HALF_BIT;
        end
      end
      ST_START: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
          baud_d  = FULL_BIT;
          bit_d   = '0;
          bad_d   = 1'b0;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d  = FULL_BIT;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d  = FULL_BIT;
          state_d = ST_STOP;
          if (rx_s != data_parity(8'(shift_q), ODD)) begin
            bad_d      = 1'b1;
            parity_evt = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d = FULL_BIT;
          // A low stop bit may be a break; wait for the line to recover.
          if (!rx_s) begin
            frame_evt = 1'b1;
            bit_d     = '0;
            state_d   = ST_WAIT_HIGH;
          end else if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_IDLE;
            push    = !bad_q;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop in the same cycle makes room, so only an unserviced full FIFO overruns.
  always_comb begin
    overrun_evt   = push && fifo_full && !rd_en;
    frame_err_d   = (frame_err_q   && !err_clr) || frame_evt;
    parity_err_d  = (parity_err_q  && !err_clr) || parity_evt;
    overrun_err_d = (overrun_err_q && !err_clr) || overrun_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 2'b11;
      state_q       <= ST_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      bad_q         <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], rx_in};
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      bad_q         <= bad_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift_q),
    .pop       (rd_en),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_valid    = !fifo_empty;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_fifo : scoreboard bench; DUT A = 8N1 depth 4, DUT B = 8E1 depth 16
// Revision: 1.0
// ============================================================================
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rx, rd_en, err_clr;
  logic [1:0] rd_valid, ferr, perr, oerr;
  logic [7:0] rd_data_a, rd_data_b;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_in(rx[0]), .rd_en(rd_en[0]), .rd_data(rd_data_a),
    .rd_valid(rd_valid[0]), .fifo_count(cnt_a), .frame_err(ferr[0]),
    .parity_err(perr[0]), .overrun_err(oerr[0]), .err_clr(err_clr[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_in(rx[1]), .rd_en(rd_en[1]), .rd_data(rd_data_b),
    .rd_valid(rd_valid[1]), .fifo_count(cnt_b), .frame_err(ferr[1]),
    .parity_err(perr[1]), .overrun_err(oerr[1]), .err_clr(err_clr[1]));

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       has_par;
    logic       par_bit;
    logic       stop;
    logic       exp_push;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[9];

  function automatic int cnt_of(input int s);
    return (s == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input int s, input logic [7:0] d, input logic has_par,
                            input logic par_bit, input logic stop_val, input logic end_lvl);
    rx[s] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[s] = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (has_par) begin
      rx[s] = par_bit;
      repeat (CPB) @(negedge clk);
    end
    rx[s] = stop_val;
    repeat (CPB) @(negedge clk);
    rx[s] = end_lvl;
  endtask

  task automatic pop_check(input int s, input string name);
    logic [7:0] exp;
    logic [7:0] act;
    exp = 8'h00;
    if (s == 0 && sb_a.size() > 0) exp = sb_a.pop_front();
    else if (s == 1 && sb_b.size() > 0) exp = sb_b.pop_front();
    else check({name, " scoreboard"}, 0, 1);
    act = (s == 0) ? rd_data_a : rd_data_b;
    check({name, " valid"}, int'(rd_valid[s]), 1);
    check({name, " data"}, int'(act), int'(exp));
    rd_en[s] = 1'b1;
    @(negedge clk);
    rd_en[s] = 1'b0;
  endtask

  task automatic pulse_clr(input int s);
    err_clr[s] = 1'b1;
    @(negedge clk);
    err_clr[s] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h41, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1, 8'h41, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n   = 1'b0;
    rx      = 2'b11;
    rd_en   = 2'b00;
    err_clr = 2'b00;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset rd_valid[%0d]", s), int'(rd_valid[s]), 0);
      check($sformatf("reset count[%0d]", s), cnt_of(s), 0);
      check($sformatf("reset frame_err[%0d]", s), int'(ferr[s]), 0);
      check($sformatf("reset parity_err[%0d]", s), int'(perr[s]), 0);
      check($sformatf("reset overrun_err[%0d]", s), int'(oerr[s]), 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Back-to-back 8N1 characters; rd_valid must be up as soon as the frame ends.
    sb_a.push_back(8'h41);
    sb_a.push_back(8'h42);
    send_frame(0, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1);
    check("b2b count", cnt_of(0), 2);
    check("b2b frame_err", int'(ferr[0]), 0);
    check("b2b overrun_err", int'(oerr[0]), 0);
    pop_check(0, "b2b first");
    pop_check(0, "b2b second");
    check("b2b drained", cnt_of(0), 0);

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].sel, vecs[v].data, vecs[v].has_par, vecs[v].par_bit,
                 vecs[v].stop, 1'b1);
      repeat (4) @(negedge clk);
      if (vecs[v].exp_push) begin
        if (vecs[v].sel == 0) sb_a.push_back(vecs[v].data);
        else sb_b.push_back(vecs[v].data);
      end
      check($sformatf("vec%0d count", v), cnt_of(vecs[v].sel), int'(vecs[v].exp_push));
      check($sformatf("vec%0d frame_err", v), int'(ferr[vecs[v].sel]), int'(vecs[v].exp_ferr));
      check($sformatf("vec%0d parity_err", v), int'(perr[vecs[v].sel]), int'(vecs[v].exp_perr));
      if (vecs[v].exp_push) pop_check(vecs[v].sel, $sformatf("vec%0d pop", v));
      pulse_clr(vecs[v].sel);
      check($sformatf("vec%0d clr frame_err", v), int'(ferr[vecs[v].sel]), 0);
      check($sformatf("vec%0d clr parity_err", v), int'(perr[vecs[v].sel]), 0);
    end

    // Start-bit glitch shorter than half a bit.
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch count", cnt_of(0), 0);
    check("glitch state", int'(u_a.state_q), int'(ST_IDLE));
    check("glitch frame_err", int'(ferr[0]), 0);

    // Low stop bit followed by a held-low line.
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    check("break frame_err", int'(ferr[0]), 1);
    check("break count", cnt_of(0), 0);
    check("break state", int'(u_a.state_q), int'(ST_WAIT_HIGH));
    rx[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("break recover state", int'(u_a.state_q), int'(ST_IDLE));
    check("break recover count", cnt_of(0), 0);
    pulse_clr(0);
    check("break clr", int'(ferr[0]), 0);

    // Overrun on the 4-deep FIFO.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb_a.push_back(8'h11 + 8'(i));
      send_frame(0, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b1);
    end
    repeat (2) @(negedge clk);
    check("ovr count", cnt_of(0), 4);
    check("ovr overrun_err", int'(oerr[0]), 1);
    check("ovr frame_err", int'(ferr[0]), 0);
    for (int i = 0; i < 4; i++) pop_check(0, $sformatf("ovr head%0d", i));
    check("ovr drained valid", int'(rd_valid[0]), 0);
    rd_en[0] = 1'b1;
    @(negedge clk);
    rd_en[0] = 1'b0;
    check("pop empty count", cnt_of(0), 0);
    check("ovr sticky", int'(oerr[0]), 1);
    pulse_clr(0);
    check("ovr clr", int'(oerr[0]), 0);

    // Reset in the middle of the data bits of 0x33 with one char already queued.
    sb_a.push_back(8'h77);
    send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("pre-reset count", cnt_of(0), 1);
    rx[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx[0] = (8'h33 >> i) & 8'h01 ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    sb_a.delete();
    sb_b.delete();
    @(negedge clk);
    check("midrst count", cnt_of(0), 0);
    check("midrst valid", int'(rd_valid[0]), 0);
    check("midrst state", int'(u_a.state_q), int'(ST_IDLE));
    rx[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    sb_a.push_back(8'h34);
    send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("post-reset count", cnt_of(0), 1);
    pop_check(0, "post-reset");
    check("post-reset frame_err", int'(ferr[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
